udp_packet_tx: RTL and testbench

Transmit-side framer for the 40Gbps UDP parser datapath. Takes one 16-bit op code and 489 32-bit payload words per packet. Emits the fixed 63-beat, 256-bit packet format that the parser consumes: header beat, op code beat, payload beats and a half-payload last beat, under valid/ready backpressure. It sits in front of the parser in loopback benches and in the traffic-generation path.

---
 rtl/udp_packet_tx_if.sv | 24 ++
 rtl/udp_packet_tx.sv | 122 ++++++++++++
 tb/tb_udp_packet_tx.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_packet_tx_if.sv
// Stream bundle for udp_packet_tx: command, payload-word and packet-beat channels.
// The master side feeds commands and words and accepts beats; the slave side is the framer.
interface udp_packet_tx_if;
    logic [15:0]  op_code;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [31:0]  word_data;
    logic         word_valid;
    logic         word_ready;
    logic [255:0] Out_data;
    logic         Out_valid;
    logic         Out_ready;
    logic         Out_last;

    modport master (
        output op_code, cmd_valid, word_data, word_valid, Out_ready,
        input  cmd_ready, word_ready, Out_data, Out_valid, Out_last
    );

    modport slave (
        input  op_code, cmd_valid, word_data, word_valid, Out_ready,
        output cmd_ready, word_ready, Out_data, Out_valid, Out_last
    );
endinterface

// File: rtl/udp_packet_tx.sv
// Transmit framer: packs one op code and 489 payload words into a fixed
// 63-beat 256-bit packet (header, op code + 5 words, 60 x 8 words, 4 words).
module udp_packet_tx #(
    parameter logic [255:0] HEADER_BEAT0 = 256'h0,
    parameter logic [79:0]  HEADER_HI    = 80'h0
) (
    input  logic              clk,
    input  logic              reset,
    udp_packet_tx_if.slave    bus,
    output logic              err_opcode,
    output logic [15:0]       pkt_count
);

    typedef enum logic [1:0] {IDLE, HDR, FILL, SEND} state_t;

    localparam logic [5:0] LAST_BEAT = 6'd62;

    state_t       state_q, state_d;
    logic [5:0]   beat_q, beat_d;
    logic [2:0]   lane_q, lane_d;
    logic [255:0] buf_q, buf_d;
    logic [255:0] out_data_q, out_data_d;
    logic [15:0]  op_q, op_d;
    logic [15:0]  pkt_count_q, pkt_count_d;
    logic         err_q, err_d;
    logic         final_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            lane_q      <= '0;
            buf_q       <= '0;
            out_data_q  <= '0;
            op_q        <= '0;
            pkt_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            lane_q      <= lane_d;
            buf_q       <= buf_d;
            out_data_q  <= out_data_d;
            op_q        <= op_d;
            pkt_count_q <= pkt_count_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        lane_d      = lane_q;
        buf_d       = buf_q;
        out_data_d  = out_data_q;
        op_d        = op_q;
        pkt_count_d = pkt_count_q;
        err_d       = 1'b0;
        final_word  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.op_code == 16'd1 || bus.op_code == 16'd2) begin
                        op_d       = bus.op_code;
                        beat_d     = '0;
                        out_data_d = HEADER_BEAT0;
                        state_d    = HDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            HDR: begin
                if (bus.Out_ready) begin
                    beat_d  = 6'd1;
                    buf_d   = '0;
                    lane_d  = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (bus.word_valid) begin
                    buf_d[{lane_q, 5'b0} +: 32] = bus.word_data;
                    lane_d     = lane_q + 3'd1;
                    // Beat 1 ends after lane 4; the upper lanes carry header and op code.
                    final_word = (beat_q == 6'd1) ? (lane_q == 3'd4) : (lane_q == 3'd7);
                    if (final_word) begin
                        out_data_d = (beat_q == 6'd1) ? {HEADER_HI, op_q, buf_d[159:0]} : buf_d;
                        state_d    = SEND;
                    end
                end
            end
            SEND: begin
                if (bus.Out_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        pkt_count_d = pkt_count_q + 16'd1;
                        state_d     = IDLE;
                    end else begin
                        beat_d  = beat_q + 6'd1;
                        buf_d   = '0;
                        // The last beat only carries words in its upper half.
                        lane_d  = (beat_q == LAST_BEAT - 6'd1) ? 3'd4 : 3'd0;
                        state_d = FILL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready  = (state_q == IDLE);
        bus.word_ready = (state_q == FILL);
        bus.Out_valid  = (state_q == HDR) || (state_q == SEND);
        bus.Out_last   = (state_q == SEND) && (beat_q == LAST_BEAT);
        bus.Out_data   = out_data_q;
        err_opcode     = err_q;
        pkt_count      = pkt_count_q;
    end

endmodule

// File: tb/tb_udp_packet_tx.sv
// Self-checking bench for udp_packet_tx: a packet-level model builds the expected
// 63 beats from the op code and word list; a monitor checks every accepted beat.
module tb_udp_packet_tx;

    localparam logic [255:0] HB0 = 256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF;
    localparam logic [79:0]  HHI = 80'hDEADBEEF_CAFEF00D_1234;

    logic        clk = 1'b0;
    logic        reset;
    logic        err_opcode;
    logic [15:0] pkt_count;

    udp_packet_tx_if bus();

    udp_packet_tx #(.HEADER_BEAT0(HB0), .HEADER_HI(HHI)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .err_opcode (err_opcode),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0]  w [489];
    logic [255:0] exp_q [$];
    logic [255:0] cap [63];
    int           rx_beat = 0;
    int           pkts_rx = 0;
    int           beats_in_pkt = 0;
    bit           stall_req = 0;
    int           stall_beat = 30;
    int           stall_left = 0;
    bit           abort = 0;
    bit           prev_valid = 0;
    bit           prev_ready = 0;
    logic [255:0] prev_data;
    logic         prev_last;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic timeout(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Expected packet straight from the format: lanes filled in word order.
    task automatic build_expected(input logic [15:0] op);
        logic [255:0] b;
        exp_q.push_back(HB0);
        b = '0;
        for (int j = 0; j < 5; j++) b[32*j +: 32] = w[j];
        b[175:160] = op;
        b[255:176] = HHI;
        exp_q.push_back(b);
        for (int k = 2; k <= 61; k++) begin
            b = '0;
            for (int j = 0; j < 8; j++) b[32*j +: 32] = w[5 + (k - 2) * 8 + j];
            exp_q.push_back(b);
        end
        b = '0;
        for (int j = 4; j < 8; j++) b[32*j +: 32] = w[485 + j - 4];
        exp_q.push_back(b);
    endtask

    task automatic payload_stats(output longint sum, output logic [31:0] mx);
        logic [31:0] v;
        sum = 0;
        mx  = '0;
        for (int k = 1; k <= 62; k++) begin
            for (int j = 0; j < 8; j++) begin
                if ((k == 1 && j < 5) || (k > 1 && k < 62) || (k == 62 && j >= 4)) begin
                    v = cap[k][32*j +: 32];
                    sum += longint'(v);
                    if (v > mx) mx = v;
                end
            end
        end
    endtask

    task automatic set_words_seq();
        for (int i = 0; i < 489; i++) w[i] = i + 1;
    endtask

    task automatic send_packet(input logic [15:0] op, input bit toggle);
        int n;
        @(negedge clk);
        bus.op_code   = op;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 100 && !abort) begin @(negedge clk); n++; end
        if (abort) begin bus.cmd_valid = 1'b0; return; end
        if (n >= 100) begin timeout("cmd_wait"); bus.cmd_valid = 1'b0; return; end
        @(posedge clk);
        for (int i = 0; i < 489; i++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            if (toggle && i > 0) begin
                bus.word_valid = 1'b0;
                @(negedge clk);
            end
            bus.word_valid = 1'b1;
            bus.word_data  = w[i];
            n = 0;
            while (!bus.word_ready && n < 200 && !abort) begin @(negedge clk); n++; end
            if (abort) begin bus.word_valid = 1'b0; return; end
            if (n >= 200) begin timeout("word_wait"); bus.word_valid = 1'b0; return; end
            @(posedge clk);
        end
        @(negedge clk);
        bus.word_valid = 1'b0;
    endtask

    task automatic wait_packet(input int start);
        int n = 0;
        while (pkts_rx == start && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) timeout("packet_done");
    endtask

    task automatic run_packet(input logic [15:0] op, input bit toggle);
        int start = pkts_rx;
        build_expected(op);
        send_packet(op, toggle);
        wait_packet(start);
        check("beats_per_packet", 256'(beats_in_pkt), 256'd63);
        check("leftover_expected", 256'(exp_q.size()), 256'd0);
    endtask

    // Drives Out_ready, then checks the beat on offer against the model.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            rx_beat       = 0;
            prev_valid    = 0;
            stall_left    = 0;
            bus.Out_ready = 1'b1;
        end else begin
            if (stall_req && bus.Out_valid && rx_beat == stall_beat && stall_left == 0) begin
                stall_left = 5;
                stall_req  = 0;
            end
            if (stall_left > 0) begin
                bus.Out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.Out_ready = 1'b1;
            end
            if (bus.Out_valid) begin
                check("word_ready_while_beat", 256'(bus.word_ready), 256'd0);
                if (prev_valid && !prev_ready) begin
                    check("stall_data_stable", bus.Out_data, prev_data);
                    check("stall_last_stable", 256'(bus.Out_last), 256'(prev_last));
                end
                if (bus.Out_ready) begin
                    if (exp_q.size() == 0) begin
                        timeout("unexpected_beat");
                    end else begin
                        check($sformatf("beat%0d_data", rx_beat), bus.Out_data, exp_q.pop_front());
                        check($sformatf("beat%0d_last", rx_beat), 256'(bus.Out_last), 256'(rx_beat == 62));
                    end
                    if (rx_beat < 63) cap[rx_beat] = bus.Out_data;
                    rx_beat++;
                    if (rx_beat == 63) begin
                        beats_in_pkt = rx_beat;
                        rx_beat      = 0;
                        pkts_rx++;
                    end
                end
            end
            prev_valid = bus.Out_valid;
            prev_ready = bus.Out_ready;
            prev_data  = bus.Out_data;
            prev_last  = bus.Out_last;
        end
    end

    initial begin
        longint      sum;
        logic [31:0] mx;
        int          n;

        reset          = 1'b1;
        bus.op_code    = '0;
        bus.cmd_valid  = 1'b0;
        bus.word_data  = '0;
        bus.word_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 256'(bus.Out_valid), 256'd0);
        check("rst_out_data", bus.Out_data, 256'd0);
        check("rst_out_last", 256'(bus.Out_last), 256'd0);
        check("rst_word_ready", 256'(bus.word_ready), 256'd0);
        check("rst_err", 256'(err_opcode), 256'd0);
        check("rst_pkt_count", 256'(pkt_count), 256'd0);
        reset = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_reset", 256'(bus.cmd_ready), 256'd1);

        // Scenario 1: op 1, words 1..489
        set_words_seq();
        run_packet(16'd1, 1'b0);
        check("s1_beat0", cap[0], HB0);
        check("s1_b1_op", 256'(cap[1][175:160]), 256'd1);
        check("s1_b1_lane0", 256'(cap[1][31:0]), 256'd1);
        check("s1_b1_lane4", 256'(cap[1][159:128]), 256'd5);
        check("s1_b2_lane0", 256'(cap[2][31:0]), 256'd6);
        check("s1_b62_lane4", 256'(cap[62][159:128]), 256'd486);
        check("s1_b62_lane7", 256'(cap[62][255:224]), 256'd489);
        check("s1_b62_low", 256'(cap[62][127:0]), 256'd0);
        payload_stats(sum, mx);
        check("s1_sum", 256'(sum), 256'd119805);
        check("s1_pkt_count", 256'(pkt_count), 256'd1);

        // Scenario 2: op 2 with a large word 300
        w[299] = 32'hFFFF0000;
        run_packet(16'd2, 1'b0);
        payload_stats(sum, mx);
        check("s2_max", 256'(mx), 256'hFFFF0000);
        check("s2_b1_op", 256'(cap[1][175:160]), 256'd2);
        check("s2_pkt_count", 256'(pkt_count), 256'd2);

        // Scenario 3: downstream stall on beat 30
        set_words_seq();
        stall_beat = 30;
        stall_req  = 1;
        run_packet(16'd1, 1'b0);
        check("s3_stall_consumed", 256'(stall_req), 256'd0);
        check("s3_pkt_count", 256'(pkt_count), 256'd3);

        // Scenario 4: gappy word source
        run_packet(16'd1, 1'b1);
        payload_stats(sum, mx);
        check("s4_sum", 256'(sum), 256'd119805);
        check("s4_pkt_count", 256'(pkt_count), 256'd4);

        // Scenario 5: rejected op code then a good packet
        @(negedge clk);
        bus.op_code   = 16'd3;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("s5_err_pulse", 256'(err_opcode), 256'd1);
        check("s5_no_beat", 256'(bus.Out_valid), 256'd0);
        check("s5_cmd_ready", 256'(bus.cmd_ready), 256'd1);
        @(negedge clk);
        check("s5_err_cleared", 256'(err_opcode), 256'd0);
        check("s5_still_idle", 256'(bus.Out_valid), 256'd0);
        run_packet(16'd1, 1'b0);
        check("s5_pkt_count", 256'(pkt_count), 256'd5);

        // Scenario 6: reset while beat 20 is on offer
        build_expected(16'd1);
        fork
            send_packet(16'd1, 1'b0);
            begin
                n = 0;
                do begin
                    @(posedge clk);
                    #2;
                    n++;
                end while (!(rx_beat == 20 && bus.Out_valid) && n < 2000);
                if (n >= 2000) timeout("beat20_wait");
                reset = 1'b1;
                abort = 1'b1;
            end
        join
        @(posedge clk);
        @(negedge clk);
        check("s6_out_valid", 256'(bus.Out_valid), 256'd0);
        check("s6_pkt_count", 256'(pkt_count), 256'd0);
        reset          = 1'b0;
        abort          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.word_valid = 1'b0;
        @(negedge clk);
        run_packet(16'd1, 1'b0);
        check("s6_beat0", cap[0], HB0);
        check("s6_b62_lane7", 256'(cap[62][255:224]), 256'd489);
        check("s6_pkt_count_after", 256'(pkt_count), 256'd1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
